// File: rtl/teletext_row_buffer_if.sv
// Character-path bundle between the character source / renderer and the teletext row buffer.
// The master side drives characters, requests and timing pulses; the slave side is the buffer.
interface teletext_row_buffer_if #(
    parameter int CHAR_WIDTH     = 7,
    parameter int SCANLINE_WIDTH = 4
);
    logic                      character__valid;
    logic [CHAR_WIDTH-1:0]     character__character;
    logic                      char_request;
    logic                      timings__restart_frame;
    logic                      timings__end_of_scanline;
    logic                      clear_overflow;
    logic                      out_character__valid;
    logic [CHAR_WIDTH-1:0]     out_character__character;
    logic [SCANLINE_WIDTH-1:0] scanline_in_row;
    logic                      first_scanline_of_row;
    logic                      overflow;

    modport master (
        output character__valid,
        output character__character,
        output char_request,
        output timings__restart_frame,
        output timings__end_of_scanline,
        output clear_overflow,
        input  out_character__valid,
        input  out_character__character,
        input  scanline_in_row,
        input  first_scanline_of_row,
        input  overflow
    );

    modport slave (
        input  character__valid,
        input  character__character,
        input  char_request,
        input  timings__restart_frame,
        input  timings__end_of_scanline,
        input  clear_overflow,
        output out_character__valid,
        output out_character__character,
        output scanline_in_row,
        output first_scanline_of_row,
        output overflow
    );
endinterface

// File: rtl/teletext_row_buffer.sv
// Captures one character row on its first scanline and replays it on renderer demand for the
// remaining scanlines of the row, padding short rows with a fill character.
module teletext_row_buffer #(
    parameter int                   COLUMNS           = 40,
    parameter int                   CHAR_WIDTH        = 7,
    parameter int                   SCANLINES_PER_ROW = 10,
    parameter int                   PTR_WIDTH         = 6,
    parameter int                   SCANLINE_WIDTH    = 4,
    parameter logic [CHAR_WIDTH-1:0] FILL_CHARACTER   = CHAR_WIDTH'(7'h20)
) (
    input  logic                  clk,
    input  logic                  clk__enable,
    input  logic                  reset_n,
    teletext_row_buffer_if.slave  bus
);

    localparam int ADDR_WIDTH = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam logic [PTR_WIDTH-1:0]      COLS_P        = PTR_WIDTH'(COLUMNS);
    localparam logic [SCANLINE_WIDTH-1:0] LAST_SCANLINE = SCANLINE_WIDTH'(SCANLINES_PER_ROW - 1);

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_CAPTURE    = 2'd1,
        ST_REPLAY     = 2'd2
    } state_e;

    state_e                    state_r;
    state_e                    state_nxt_s;
    logic [PTR_WIDTH-1:0]      wr_ptr_r;
    logic [PTR_WIDTH-1:0]      rd_ptr_r;
    logic [PTR_WIDTH-1:0]      count_r;
    logic [SCANLINE_WIDTH-1:0] scanline_r;
    logic                      out_valid_r;
    logic [CHAR_WIDTH-1:0]     out_char_r;
    logic                      overflow_r;
    logic [CHAR_WIDTH-1:0]     mem_r [COLUMNS];

    logic                      accept_s;
    logic [ADDR_WIDTH-1:0]     wr_addr_s;
    logic [PTR_WIDTH-1:0]      wr_ptr_nxt_s;
    logic [PTR_WIDTH-1:0]      rd_ptr_nxt_s;
    logic [PTR_WIDTH-1:0]      count_nxt_s;
    logic [SCANLINE_WIDTH-1:0] scanline_nxt_s;
    logic                      out_valid_nxt_s;
    logic [CHAR_WIDTH-1:0]     out_char_nxt_s;
    logic                      overflow_nxt_s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_WAIT_FRAME;
        end else if (clk__enable) begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a frame restart overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.timings__restart_frame) begin
            state_nxt_s = ST_CAPTURE;
        end else begin
            case (state_r)
                ST_WAIT_FRAME: state_nxt_s = ST_WAIT_FRAME;
                ST_CAPTURE: begin
                    if (bus.timings__end_of_scanline) state_nxt_s = ST_REPLAY;
                    else                              state_nxt_s = ST_CAPTURE;
                end
                ST_REPLAY: begin
                    if (bus.timings__end_of_scanline && (scanline_r == LAST_SCANLINE))
                        state_nxt_s = ST_CAPTURE;
                    else
                        state_nxt_s = ST_REPLAY;
                end
                default: state_nxt_s = ST_WAIT_FRAME;
            endcase
        end
    end

    // Output / datapath decode: what each event does to pointers, counters and the output stage.
    always_comb begin
        accept_s        = 1'b0;
        wr_addr_s       = wr_ptr_r[ADDR_WIDTH-1:0];
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        count_nxt_s     = count_r;
        scanline_nxt_s  = scanline_r;
        out_valid_nxt_s = 1'b0;
        out_char_nxt_s  = out_char_r;
        overflow_nxt_s  = overflow_r;
        if (bus.timings__restart_frame) begin
            scanline_nxt_s = {SCANLINE_WIDTH{1'b0}};
            rd_ptr_nxt_s   = {PTR_WIDTH{1'b0}};
            count_nxt_s    = {PTR_WIDTH{1'b0}};
            // A character coinciding with the restart becomes column 0 of the new row.
            if (bus.character__valid) begin
                accept_s        = 1'b1;
                wr_addr_s       = {ADDR_WIDTH{1'b0}};
                wr_ptr_nxt_s    = PTR_WIDTH'(1);
                out_valid_nxt_s = 1'b1;
                out_char_nxt_s  = bus.character__character;
            end else begin
                wr_ptr_nxt_s    = {PTR_WIDTH{1'b0}};
            end
            if (bus.clear_overflow) overflow_nxt_s = 1'b0;
            else                    overflow_nxt_s = overflow_r;
        end else begin
            case (state_r)
                ST_CAPTURE: begin
                    if (bus.character__valid && (wr_ptr_r < COLS_P)) begin
                        accept_s        = 1'b1;
                        wr_ptr_nxt_s    = wr_ptr_r + PTR_WIDTH'(1);
                        out_valid_nxt_s = 1'b1;
                        out_char_nxt_s  = bus.character__character;
                        overflow_nxt_s  = bus.clear_overflow ? 1'b0 : overflow_r;
                    end else if (bus.character__valid) begin
                        overflow_nxt_s  = 1'b1;
                    end else begin
                        overflow_nxt_s  = bus.clear_overflow ? 1'b0 : overflow_r;
                    end
                    // The count includes a character accepted on the closing cycle.
                    if (bus.timings__end_of_scanline) begin
                        count_nxt_s    = wr_ptr_nxt_s;
                        scanline_nxt_s = SCANLINE_WIDTH'(1);
                        rd_ptr_nxt_s   = {PTR_WIDTH{1'b0}};
                    end else begin
                        count_nxt_s    = count_r;
                    end
                end
                ST_REPLAY: begin
                    if (bus.character__valid) overflow_nxt_s = 1'b1;
                    else if (bus.clear_overflow) overflow_nxt_s = 1'b0;
                    else overflow_nxt_s = overflow_r;
                    if (bus.char_request && (rd_ptr_r < count_r)) begin
                        out_valid_nxt_s = 1'b1;
                        out_char_nxt_s  = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
                        rd_ptr_nxt_s    = rd_ptr_r + PTR_WIDTH'(1);
                    end else if (bus.char_request) begin
                        out_valid_nxt_s = 1'b1;
                        out_char_nxt_s  = FILL_CHARACTER;
                    end else begin
                        rd_ptr_nxt_s    = rd_ptr_r;
                    end
                    // A request on the closing cycle is served first, then the read pointer rewinds.
                    if (bus.timings__end_of_scanline) begin
                        rd_ptr_nxt_s = {PTR_WIDTH{1'b0}};
                        if (scanline_r == LAST_SCANLINE) begin
                            scanline_nxt_s = {SCANLINE_WIDTH{1'b0}};
                            wr_ptr_nxt_s   = {PTR_WIDTH{1'b0}};
                        end else begin
                            scanline_nxt_s = scanline_r + SCANLINE_WIDTH'(1);
                        end
                    end else begin
                        scanline_nxt_s = scanline_r;
                    end
                end
                default: begin
                    overflow_nxt_s = overflow_r;
                end
            endcase
        end
    end

    // Pointer, counter, flag and output-stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= {PTR_WIDTH{1'b0}};
            rd_ptr_r    <= {PTR_WIDTH{1'b0}};
            count_r     <= {PTR_WIDTH{1'b0}};
            scanline_r  <= {SCANLINE_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_char_r  <= {CHAR_WIDTH{1'b0}};
            overflow_r  <= 1'b0;
        end else if (clk__enable) begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            scanline_r  <= scanline_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_char_r  <= out_char_nxt_s;
            overflow_r  <= overflow_nxt_s;
        end
    end

    // Row storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (clk__enable && accept_s) begin
            mem_r[wr_addr_s] <= bus.character__character;
        end
    end

    assign bus.out_character__valid     = out_valid_r;
    assign bus.out_character__character = out_char_r;
    assign bus.scanline_in_row          = scanline_r;
    assign bus.first_scanline_of_row    = (state_r == ST_CAPTURE);
    assign bus.overflow                 = overflow_r;

endmodule

// File: tb/tb_teletext_row_buffer.sv
// Table-driven bench for teletext_row_buffer (4 columns, 10 scanlines) with a scoreboard
// queue holding the characters expected on the output strobe.
module tb_teletext_row_buffer;
    localparam int CW = 7;
    localparam int SW = 4;

    typedef struct {
        bit             en;
        bit             rf;
        bit             eos;
        bit             vld;
        logic [CW-1:0]  ch;
        bit             req;
        bit             clr;
        bit             exp_out;
        logic [CW-1:0]  exp_ch;
        int             exp_scan;
        bit             exp_first;
        bit             exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic clk__enable;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] mon_exp;
    vec_t tbl[$];
    vec_t tbl2[$];

    teletext_row_buffer_if #(.CHAR_WIDTH(CW), .SCANLINE_WIDTH(SW)) bus ();

    teletext_row_buffer #(
        .COLUMNS(4), .CHAR_WIDTH(CW), .SCANLINES_PER_ROW(10), .PTR_WIDTH(3),
        .SCANLINE_WIDTH(SW), .FILL_CHARACTER(7'h20)
    ) dut (
        .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit en, bit rf, bit eos, bit vld, logic [CW-1:0] ch, bit req, bit clr,
                                bit eo, logic [CW-1:0] ech, int scan, bit first, bit ovf);
        vec_t v;
        v.en = en; v.rf = rf; v.eos = eos; v.vld = vld; v.ch = ch; v.req = req; v.clr = clr;
        v.exp_out = eo; v.exp_ch = ech; v.exp_scan = scan; v.exp_first = first; v.exp_ovf = ovf;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        clk__enable                  = v.en;
        bus.timings__restart_frame   = v.rf;
        bus.timings__end_of_scanline = v.eos;
        bus.character__valid         = v.vld;
        bus.character__character     = v.ch;
        bus.char_request             = v.req;
        bus.clear_overflow           = v.clr;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(bus.out_character__valid), 32'(v.exp_out));
        if (v.exp_out) exp_q.push_back(v.exp_ch);
        check({tag, "_scanline"}, 32'(bus.scanline_in_row), 32'(v.exp_scan));
        check({tag, "_first"}, 32'(bus.first_scanline_of_row), 32'(v.exp_first));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(v.exp_ovf));
    endtask

    // Scoreboard: every output strobe must match the oldest expected character.
    always @(negedge clk) begin
        if (bus.out_character__valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_char", 32'(bus.out_character__character), 32'(mon_exp));
            end
        end
    end

    initial begin
        //              en rf eos vld ch    req clr  eo  ech   scan first ovf
        tbl.push_back(mk(1, 0, 1, 1, 7'h41, 1, 0,   0, 7'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 7'h00, 0, 0,   0, 7'h00, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 7'h41, 0, 0,   1, 7'h41, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 7'h42, 0, 0,   1, 7'h42, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 7'h43, 0, 0,   1, 7'h43, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   0, 7'h00, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,   0, 7'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h41, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h42, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h43, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h20, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h20, 1, 0, 0));
        for (int s = 2; s <= 9; s++) begin
            tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0, 0, 7'h00, s, 0, 0));
            tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0, 1, 7'h41, s, 0, 0));
        end
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,   0, 7'h00, 0, 1, 0));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk(1, 0, 0, 1, 7'(8'h50 + i), 0, 0, (i < 4), 7'(8'h50 + i), 0, 1, (i >= 4)));
        end
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,   0, 7'h00, 1, 0, 1));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0, 1, (i < 4) ? 7'(8'h50 + i) : 7'h20, 1, 0, 1));
        end
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 0, 1,   0, 7'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 7'h66, 0, 0,   0, 7'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 0, 1,   0, 7'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 7'h67, 0, 1,   0, 7'h00, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 0, 1,   0, 7'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 1, 0,   1, 7'h20, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h50, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,   0, 7'h00, 3, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,   0, 7'h00, 4, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,   0, 7'h00, 5, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 7'h60, 0, 0,   1, 7'h60, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 7'h61, 0, 0,   1, 7'h61, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h60, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h61, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h20, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 0, 0,   0, 7'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 7'h68, 1, 0,   0, 7'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,   1, 7'h20, 1, 0, 0));
        // After a mid-row reset: back in WAIT_FRAME until the next restart.
        tbl2.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,  0, 7'h00, 0, 0, 0));
        tbl2.push_back(mk(1, 0, 1, 1, 7'h71, 1, 0,  0, 7'h00, 0, 0, 0));
        tbl2.push_back(mk(1, 1, 0, 1, 7'h77, 0, 0,  1, 7'h77, 0, 1, 0));
        tbl2.push_back(mk(1, 0, 1, 0, 7'h00, 0, 0,  0, 7'h00, 1, 0, 0));
        tbl2.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,  1, 7'h77, 1, 0, 0));
        tbl2.push_back(mk(1, 0, 0, 0, 7'h00, 1, 0,  1, 7'h20, 1, 0, 0));

        drive(mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0));
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(bus.out_character__valid), 32'd0);
        check("reset_out_char", 32'(bus.out_character__character), 32'd0);
        check("reset_scanline", 32'(bus.scanline_in_row), 32'd0);
        check("reset_first", 32'(bus.first_scanline_of_row), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // Asynchronous reset while an output pulse and the overflow flag are both high.
        @(negedge clk);
        drive(mk(1, 0, 0, 1, 7'h70, 1, 0, 0, 7'h00, 0, 0, 0));
        @(posedge clk);
        #1;
        check("midrow_pre_valid", 32'(bus.out_character__valid), 32'd1);
        check("midrow_pre_overflow", 32'(bus.overflow), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midrow_out_valid", 32'(bus.out_character__valid), 32'd0);
        check("midrow_out_char", 32'(bus.out_character__character), 32'd0);
        check("midrow_scanline", 32'(bus.scanline_in_row), 32'd0);
        check("midrow_first", 32'(bus.first_scanline_of_row), 32'd0);
        check("midrow_overflow", 32'(bus.overflow), 32'd0);
        drive(mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i], $sformatf("w%0d", i));

        @(negedge clk);
        drive(mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/teletext_row_buffer.md
Name: teletext_row_buffer

Overview:
- Parametrised character row buffer between the character source and the teletext renderer.
- On the first scanline of each character row it captures up to COLUMNS incoming characters and passes them through.
- On the remaining SCANLINES_PER_ROW-1 scanlines it replays the stored row on renderer demand, so the source sends each row only once.
- Generalises the fixed 40-column, 10-scanline arrangement to configurable width and depth, and adds overflow detection and fill-character padding.

Parameters:
COLUMNS, 40, maximum characters stored per row
CHAR_WIDTH, 7, bits per character code
SCANLINES_PER_ROW, 10, scanlines per character row (minimum 2)
PTR_WIDTH, 6, pointer/count width; must satisfy 2**PTR_WIDTH > COLUMNS
SCANLINE_WIDTH, 4, scanline counter width; must satisfy 2**SCANLINE_WIDTH >= SCANLINES_PER_ROW
FILL_CHARACTER, 7'h20, code emitted for replay requests beyond the captured count

Ports:
clk  input  1  clock, rising edge
clk__enable  input  1  clock enable; when low, all state holds
reset_n  input  1  asynchronous active-low reset
character__valid  input  1  incoming character strobe
character__character  input  CHAR_WIDTH  incoming character code
char_request  input  1  renderer request for the next character (replay only)
timings__restart_frame  input  1  frame restart pulse
timings__end_of_scanline  input  1  end-of-scanline pulse
clear_overflow  input  1  clears the overflow flag
out_character__valid  output  1  outgoing character strobe
out_character__character  output  CHAR_WIDTH  outgoing character code
scanline_in_row  output  SCANLINE_WIDTH  current scanline within the row
first_scanline_of_row  output  1  high while the state is CAPTURE
overflow  output  1  sticky flag: a character was dropped

Behaviour:
- Single clock clk, gated by clk__enable. Reset is asynchronous and active-low on reset_n.
- Reset values: state WAIT_FRAME; all outputs 0; wr_ptr, rd_ptr, count and scanline are 0. Buffer contents are undefined.
- Storage: COLUMNS x CHAR_WIDTH array, synchronous write, registered read.
- FSM states: WAIT_FRAME, CAPTURE, REPLAY.
- WAIT_FRAME:
  - All inputs except restart_frame are ignored; outputs held at 0.
  - restart_frame -> CAPTURE, with scanline=0, wr_ptr=0, count=0.
- CAPTURE:
  - character__valid with wr_ptr<COLUMNS: write buffer[wr_ptr]; wr_ptr++.
  - Same character is registered to out_character__* one cycle later (valid pulse of 1 cycle). Latency 1.
  - character__valid with wr_ptr==COLUMNS: character dropped, overflow set, no output pulse.
  - char_request is ignored.
  - end_of_scanline: count<=wr_ptr; scanline<=1; rd_ptr<=0 -> REPLAY.
- REPLAY:
  - char_request with rd_ptr<count: buffer[rd_ptr] is output next cycle with valid=1; rd_ptr++.
  - char_request with rd_ptr>=count: FILL_CHARACTER is output next cycle with valid=1; rd_ptr saturates (no increment).
  - character__valid in REPLAY: dropped, overflow set.
  - end_of_scanline with scanline<SCANLINES_PER_ROW-1: scanline++; rd_ptr<=0.
  - end_of_scanline with scanline==SCANLINES_PER_ROW-1: scanline<=0; wr_ptr<=0 -> CAPTURE.
- Simultaneous events:
  - character__valid with end_of_scanline in CAPTURE: the character is accepted into the ending scanline (written, counted, output) before the transition.
  - char_request with end_of_scanline in REPLAY: the request is served from the current rd_ptr, then rd_ptr resets.
  - restart_frame has priority over everything from any state: -> CAPTURE, scanline=0, pointers and count cleared. A character arriving in the same cycle is written to buffer[0] and output. Any in-flight output pulse still completes.
- clear_overflow clears overflow unless a drop occurs in the same cycle; set wins.
- first_scanline_of_row is combinational from state (high iff CAPTURE). scanline_in_row is the registered counter.
- Reset asserted mid-row returns to WAIT_FRAME immediately; captured data is discarded logically (count=0).

Test Plan:
- Reset, then restart_frame, 3 chars 0x41,0x42,0x43, then end_of_scanline -> outputs 41,42,43 each 1 cycle after input; state REPLAY; scanline_in_row=1; count=3.
- Continuing, 5 char_requests -> out 41,42,43,20,20; overflow=0.
- 9 end_of_scanline pulses with SCANLINES_PER_ROW=10 -> scanline_in_row steps 1..9, then 0 with first_scanline_of_row=1. rd_ptr restarts at 0 every scanline (first request returns 0x41).
- CAPTURE with COLUMNS=4, 6 chars -> 4 output pulses; overflow=1; replay returns the first 4 chars. clear_overflow -> overflow=0.
- char_valid during REPLAY -> overflow=1. clear_overflow in the same cycle as a drop -> overflow stays 1.
- restart_frame on the same cycle as end_of_scanline at scanline 5 -> scanline_in_row=0, CAPTURE, count=0. reset_n low mid-REPLAY -> all outputs 0 asynchronously; char_request ignored until the next restart_frame.
